// File: rtl/clb_param_pkg.sv
// Shared constants and bitstream field map for the parametrised CLB.
// The bench uses the same helpers to encode bitstreams.
package clb_param_pkg;

    typedef enum logic {
        ModeComb = 1'b0,
        ModeReg  = 1'b1
    } fle_mode_e;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int calc_m(input int n_in, input int n_fle);
        return n_in + n_fle;
    endfunction

    function automatic int calc_s(input int m);
        return clog2(m);
    endfunction

    function automatic int calc_fb(input int k, input int s);
        return (1 << k) + 1 + k * s;
    endfunction

    function automatic int calc_cfg_bits(input int n_fle, input int fb);
        return n_fle * fb;
    endfunction

    localparam int DEF_N_FLE    = 4;
    localparam int DEF_K        = 4;
    localparam int DEF_N_IN     = 10;
    localparam int DEF_M        = calc_m(DEF_N_IN, DEF_N_FLE);
    localparam int DEF_S        = calc_s(DEF_M);
    localparam int DEF_FB       = calc_fb(DEF_K, DEF_S);
    localparam int DEF_CFG_BITS = calc_cfg_bits(DEF_N_FLE, DEF_FB);

    // First config bit of element f.
    function automatic int fle_base(input int f, input int fb = DEF_FB);
        return f * fb;
    endfunction

    // Truth table sits at the bottom of each element slice.
    function automatic int lut_off();
        return 0;
    endfunction

    function automatic int mode_off(input int k = DEF_K);
        return 1 << k;
    endfunction

    function automatic int sel_off(input int j, input int k = DEF_K, input int s = DEF_S);
        return (1 << k) + 1 + j * s;
    endfunction

endpackage

// File: rtl/logical_tile_clb_param_fle.sv
// One fracturable logic element: K input muxes, a K-LUT and a bypassable flip-flop.
module logical_tile_clb_param_fle
    import clb_param_pkg::*;
#(
    parameter int unsigned K = 4,
    parameter int unsigned M = 14,
    parameter int unsigned S = 4,
    localparam int unsigned FB = (2 ** K) + 1 + K * S
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clr_i,
    input  logic [M-1:0]  src_i,
    input  logic [FB-1:0] cfg_i,
    output logic          out_o
);

    localparam int unsigned LutW = 2 ** K;

    logic [LutW-1:0] lut_tab;
    logic [K-1:0]    lut_in;
    logic            lut_out;
    fle_mode_e       mode;
    logic            ff_d;
    logic            ff_q;

    assign lut_tab = cfg_i[LutW-1:0];
    assign mode    = fle_mode_e'(cfg_i[LutW]);

    // Per-input source mux; selects beyond the source count read 0.
    for (genvar j = 0; j < K; j++) begin : g_mux
        logic [S-1:0] sel;
        assign sel       = cfg_i[LutW + 1 + j * S +: S];
        assign lut_in[j] = (32'(sel) < M) ? src_i[sel] : 1'b0;
    end

    assign lut_out = lut_tab[lut_in];

    // Flip-flop next state: held at 0 while the block is unconfigured.
    always_comb begin
        ff_d = lut_out;
        if (clr_i) ff_d = 1'b0;
    end

    // Element flip-flop.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ff_q <= 1'b0;
        end else begin
            ff_q <= ff_d;
        end
    end

    // Mode mux: registered or combinational output.
    always_comb begin
        out_o = lut_out;
        if (mode == ModeReg) out_o = ff_q;
    end

endmodule

// File: rtl/logical_tile_clb_param.sv
// Parametrised CLB: N_FLE logic elements behind a serial configuration chain.
// A load counter keeps outputs quiet until a full bitstream has been shifted in.
module logical_tile_clb_param
    import clb_param_pkg::*;
#(
    parameter int unsigned N_FLE = 4,
    parameter int unsigned K     = 4,
    parameter int unsigned N_IN  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ccff_en,
    input  logic             ccff_head,
    output logic             ccff_tail,
    input  logic [N_IN-1:0]  clb_I,
    output logic [N_FLE-1:0] clb_O,
    output logic             cfg_done
);

    localparam int unsigned M        = calc_m(N_IN, N_FLE);
    localparam int unsigned S        = calc_s(M);
    localparam int unsigned FB       = calc_fb(K, S);
    localparam int unsigned CFG_BITS = calc_cfg_bits(N_FLE, FB);
    localparam int unsigned CW       = clog2(CFG_BITS + 1);

    logic [CFG_BITS-1:0] cfg_d;
    logic [CFG_BITS-1:0] cfg_q;
    logic [CW-1:0]       cnt_d;
    logic [CW-1:0]       cnt_q;
    logic [N_FLE-1:0]    fle_out;
    logic [M-1:0]        src;
    logic                fle_clr;

    assign cfg_done  = (cnt_q == CW'(CFG_BITS));
    assign ccff_tail = cfg_q[CFG_BITS-1];
    assign fle_clr   = ~cfg_done;
    assign src       = {clb_O, clb_I};

    // Chain shift and load count; a shift after completion starts a new load at 1.
    always_comb begin
        cfg_d = cfg_q;
        cnt_d = cnt_q;
        if (ccff_en) begin
            cfg_d = {cfg_q[CFG_BITS-2:0], ccff_head};
            cnt_d = cfg_done ? CW'(1) : cnt_q + 1'b1;
        end
    end

    // Configuration chain and load counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q <= '0;
            cnt_q <= '0;
        end else begin
            cfg_q <= cfg_d;
            cnt_q <= cnt_d;
        end
    end

    for (genvar f = 0; f < N_FLE; f++) begin : g_fle
        logical_tile_clb_param_fle #(
            .K (K),
            .M (M),
            .S (S)
        ) u_fle (
            .clk_i   (clk),
            .reset_i (reset),
            .clr_i   (fle_clr),
            .src_i   (src),
            .cfg_i   (cfg_q[fle_base(f, FB) +: FB]),
            .out_o   (fle_out[f])
        );
    end

    // Outputs are forced low until a complete bitstream is present.
    always_comb begin
        clb_O = '0;
        if (cfg_done) clb_O = fle_out;
    end

endmodule

// File: tb/tb_logical_tile_clb_param.sv
// Self-checking bench for logical_tile_clb_param at default parameters.
`timescale 1ns/1ps
module tb_logical_tile_clb_param;
    import clb_param_pkg::*;

    localparam int N_FLE = 4;
    localparam int K     = 4;
    localparam int N_IN  = 10;
    localparam int M     = calc_m(N_IN, N_FLE);
    localparam int S     = calc_s(M);
    localparam int FB    = calc_fb(K, S);
    localparam int CFG   = calc_cfg_bits(N_FLE, FB);
    localparam int LW    = 1 << K;

    logic             clk;
    logic             reset;
    logic             ccff_en;
    logic             ccff_head;
    logic             ccff_tail;
    logic [N_IN-1:0]  clb_I;
    logic [N_FLE-1:0] clb_O;
    logic             cfg_done;

    int n_pass  = 0;
    int n_total = 0;

    logic [N_FLE-1:0] exp_q[$];
    string            tag_q[$];

    logical_tile_clb_param #(
        .N_FLE (N_FLE),
        .K     (K),
        .N_IN  (N_IN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ccff_en   (ccff_en),
        .ccff_head (ccff_head),
        .ccff_tail (ccff_tail),
        .clb_I     (clb_I),
        .clb_O     (clb_O),
        .cfg_done  (cfg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CFG-1:0] put_lut(input logic [CFG-1:0] bs, input int f,
                                               input logic [LW-1:0] tab);
        bs[fle_base(f, FB) + lut_off() +: LW] = tab;
        return bs;
    endfunction

    function automatic logic [CFG-1:0] put_mode(input logic [CFG-1:0] bs, input int f,
                                                input logic m);
        bs[fle_base(f, FB) + mode_off(K)] = m;
        return bs;
    endfunction

    function automatic logic [CFG-1:0] put_sel(input logic [CFG-1:0] bs, input int f,
                                               input int j, input logic [S-1:0] sel);
        bs[fle_base(f, FB) + sel_off(j, K, S) +: S] = sel;
        return bs;
    endfunction

    // Shift a bitstream in MSB first; flags cfg_done seen after 1..CFG-1 shifts.
    task automatic load_bs(input logic [CFG-1:0] bs, output logic done_early);
        done_early = 1'b0;
        for (int i = CFG - 1; i >= 0; i--) begin
            @(negedge clk);
            if (i <= CFG - 2 && cfg_done) done_early = 1'b1;
            ccff_en   = 1'b1;
            ccff_head = bs[i];
        end
        @(negedge clk);
        ccff_en   = 1'b0;
        ccff_head = 1'b0;
    endtask

    logic [CFG-1:0] bs_and;

    task automatic test_reset();
        logic [N_FLE-1:0] e;
        string t;
        reset = 1'b1; ccff_en = 1'b0; ccff_head = 1'b0; clb_I = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            clb_I = 10'($urandom);
            exp_q.push_back('0);
            tag_q.push_back("reset_clb_O");
            @(negedge clk);
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_total++;
            if (clb_O !== e) $display("FAIL %s: clb_O=%b expected %b", t, clb_O, e);
            else n_pass++;
            n_total++;
            if (ccff_tail !== 1'b0) $display("FAIL reset_tail: got %b expected 0", ccff_tail);
            else n_pass++;
            n_total++;
            if (cfg_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", cfg_done);
            else n_pass++;
        end
    endtask

    task automatic test_comb_and();
        logic             early;
        logic [N_FLE-1:0] e;
        logic [N_IN-1:0]  pats[4];
        string            t;
        bs_and = '0;
        bs_and = put_lut(bs_and, 0, 16'h8000);
        for (int j = 0; j < K; j++) bs_and = put_sel(bs_and, 0, j, S'(j));
        bs_and = put_lut(bs_and, 3, 16'hAAAA);
        bs_and = put_sel(bs_and, 3, 0, S'(15));
        bs_and = put_sel(bs_and, 3, 3, S'(8));
        load_bs(bs_and, early);
        n_total++;
        if (early !== 1'b0) $display("FAIL and_done_early: cfg_done seen before %0d shifts", CFG);
        else n_pass++;
        n_total++;
        if (cfg_done !== 1'b1) $display("FAIL and_done: got %b expected 1", cfg_done);
        else n_pass++;
        pats[0] = 10'h00F; pats[1] = 10'h00E; pats[2] = 10'h3FF; pats[3] = 10'h3F0;
        for (int i = 0; i < 12; i++) begin
            clb_I = (i < 4) ? pats[i] : 10'($urandom);
            e = '0;
            e[0] = &clb_I[3:0];
            exp_q.push_back(e);
            tag_q.push_back(i == 2 ? "fle3_sel15_zero" : "comb_and");
            #1;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_total++;
            if (clb_O !== e) $display("FAIL %s: clb_I=%h clb_O=%b expected %b", t, clb_I, clb_O, e);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_reg_buffer();
        logic             early;
        logic [CFG-1:0]   bs;
        logic [N_FLE-1:0] e;
        logic             pulse;
        string            t;
        bs = '0;
        bs = put_lut(bs, 1, 16'hAAAA);
        bs = put_mode(bs, 1, 1'b1);
        bs = put_sel(bs, 1, 0, S'(5));
        load_bs(bs, early);
        n_total++;
        if (cfg_done !== 1'b1 || early !== 1'b0)
            $display("FAIL buf_load: cfg_done=%b early=%b expected 1/0", cfg_done, early);
        else n_pass++;
        exp_q.push_back('0);
        tag_q.push_back("buf_first");
        for (int c = 0; c < 8; c++) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_total++;
            if (clb_O !== e) $display("FAIL %s: cycle %0d clb_O=%b expected %b", t, c, clb_O, e);
            else n_pass++;
            pulse = (c == 2);
            clb_I = 10'($urandom);
            clb_I[5] = pulse;
            e = '0;
            e[1] = pulse;
            exp_q.push_back(e);
            tag_q.push_back("reg_buffer");
            @(negedge clk);
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_total++;
        if (clb_O !== e) $display("FAIL %s: final clb_O=%b expected %b", t, clb_O, e);
        else n_pass++;
    endtask

    task automatic test_toggle();
        logic             early;
        logic [CFG-1:0]   bs;
        logic [N_FLE-1:0] e;
        logic             st;
        string            t;
        bs = '0;
        bs = put_lut(bs, 2, 16'h5555);
        bs = put_mode(bs, 2, 1'b1);
        bs = put_sel(bs, 2, 0, S'(N_IN + 2));
        load_bs(bs, early);
        st = 1'b0;
        exp_q.push_back('0);
        tag_q.push_back("toggle");
        for (int c = 0; c < 6; c++) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_total++;
            if (clb_O !== e) $display("FAIL %s: step %0d clb_O=%b expected %b", t, c, clb_O, e);
            else n_pass++;
            clb_I = 10'($urandom);
            st = ~st;
            e = '0;
            e[2] = st;
            exp_q.push_back(e);
            tag_q.push_back("toggle");
            @(negedge clk);
        end
        void'(exp_q.pop_front());
        void'(tag_q.pop_front());
    endtask

    task automatic test_extra_shift();
        logic             early;
        logic [N_FLE-1:0] e;
        string            t;
        load_bs(bs_and, early);
        clb_I = 10'h00F;
        #1;
        n_total++;
        if (clb_O !== 4'b0001) $display("FAIL extra_pre_out: clb_O=%b expected 0001", clb_O);
        else n_pass++;
        n_total++;
        if (ccff_tail !== bs_and[CFG-1])
            $display("FAIL extra_tail_first: got %b expected %b", ccff_tail, bs_and[CFG-1]);
        else n_pass++;
        @(negedge clk);
        ccff_en = 1'b1; ccff_head = 1'b0;
        exp_q.push_back('0);
        tag_q.push_back("extra_quiesce");
        @(negedge clk);
        ccff_en = 1'b0;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_total++;
        if (clb_O !== e) $display("FAIL %s: clb_O=%b expected %b", t, clb_O, e);
        else n_pass++;
        n_total++;
        if (cfg_done !== 1'b0) $display("FAIL extra_done_fall: got %b expected 0", cfg_done);
        else n_pass++;
        n_total++;
        if (dut.cnt_q !== 8'd1) $display("FAIL extra_cnt: got %0d expected 1", dut.cnt_q);
        else n_pass++;
        n_total++;
        if (ccff_tail !== bs_and[CFG-2])
            $display("FAIL extra_tail_next: got %b expected %b", ccff_tail, bs_and[CFG-2]);
        else n_pass++;
        for (int i = 0; i < CFG - 1; i++) begin
            @(negedge clk);
            if (i == CFG - 2) begin
                n_total++;
                if (cfg_done !== 1'b0) $display("FAIL reload_early: got %b expected 0", cfg_done);
                else n_pass++;
            end
            ccff_en = 1'b1;
            ccff_head = 1'($urandom);
        end
        @(negedge clk);
        ccff_en = 1'b0;
        n_total++;
        if (cfg_done !== 1'b1) $display("FAIL reload_done: got %b expected 1", cfg_done);
        else n_pass++;
    endtask

    task automatic test_reset_midload();
        logic early;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ccff_en = 1'b1; ccff_head = 1'b1;
        end
        @(negedge clk);
        ccff_en = 1'b0;
        n_total++;
        if (dut.cnt_q !== 8'd50) $display("FAIL mid_cnt: got %0d expected 50", dut.cnt_q);
        else n_pass++;
        reset = 1'b1;
        #2;
        n_total++;
        if (dut.cnt_q !== 8'd0) $display("FAIL rst_cnt: got %0d expected 0", dut.cnt_q);
        else n_pass++;
        n_total++;
        if (dut.cfg_q !== '0) $display("FAIL rst_cfg: got %h expected 0", dut.cfg_q);
        else n_pass++;
        #1;
        reset = 1'b0;
        n_total++;
        if (ccff_tail !== 1'b0 || cfg_done !== 1'b0)
            $display("FAIL rst_outs: tail=%b done=%b expected 0/0", ccff_tail, cfg_done);
        else n_pass++;
        load_bs(bs_and, early);
        n_total++;
        if (early !== 1'b0 || cfg_done !== 1'b1)
            $display("FAIL rst_reload: early=%b done=%b expected 0/1", early, cfg_done);
        else n_pass++;
        clb_I = 10'h00F;
        #1;
        n_total++;
        if (clb_O !== 4'b0001) $display("FAIL rst_reload_out: clb_O=%b expected 0001", clb_O);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_comb_and();
        test_reg_buffer();
        test_toggle();
        test_extra_shift();
        test_reset_midload();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
